// File: rtl/pwd_pkg.sv
// Shared types for the password checker: FSM state encoding and the display blank digit.
package pwd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_WAIT_CFM = 3'd2,
        ST_PASS     = 3'd3,
        ST_LOCKED   = 3'd4
    } state_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hE;

endpackage

// File: rtl/pwd_entry_buf.sv
// Keypad digit buffer with per-digit active-low seat mask; a write lands one cycle later.
// No backpressure: writes beyond the last digit are dropped.
module pwd_entry_buf
    import pwd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_wr,
    input  logic [3:0]            i_dat,
    output logic [4*DIGITS-1:0]   o_entry,
    output logic [DIGITS-1:0]     o_seat,
    output logic                  o_full
);

    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [IW-1:0] FULL_IDX = IW'(DIGITS);

    logic [IW-1:0]        r_idx;
    logic [4*DIGITS-1:0]  r_entry;
    logic [DIGITS-1:0]    r_seat;
    logic                 w_wr_ok;

    assign w_wr_ok = i_wr && (r_idx <= LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_entry <= '1;
            r_seat  <= '1;
        end else if (i_clr) begin
            r_idx   <= '0;
            r_entry <= {DIGITS{BLANK_DIGIT}};
            r_seat  <= '1;
        end else if (w_wr_ok) begin
            // digit 0 occupies the MSBs, so index d maps to slot DIGITS-1-d
            for (int d = 0; d < DIGITS; d++) begin
                if (r_idx == IW'(d)) begin
                    r_entry[4*(DIGITS-1-d) +: 4] <= i_dat;
                    r_seat[DIGITS-1-d]           <= 1'b0;
                end
            end
            r_idx <= r_idx + IW'(1);
        end
    end

    // Registered-only: high when the next write completes the code (or it is already complete).
    assign o_full  = (r_idx >= LAST_IDX);
    assign o_entry = r_entry;
    assign o_seat  = r_seat;

endmodule

// File: rtl/pwd_checker_n.sv
// Password checker: snapshots the code on check, compares on confirm, locks out after MAX_TRIES failures.
// All outputs registered, one cycle after the sampling edge; no backpressure. Optional PWD_LOCKOUT_TIMER_EN ends lockout.
module pwd_checker_n
    import pwd_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set,
    input  logic                  check,
    input  logic                  confirm,
    input  logic                  key_en,
    input  logic [3:0]            key_num,
    input  logic [4*DIGITS-1:0]   set_code,
    output logic [4*DIGITS-1:0]   entry,
    output logic [DIGITS-1:0]     seat,
    output logic                  busy,
    output logic                  pass,
    output logic [MAX_TRIES-1:0]  fail_leds,
    output logic                  alarm
);

    localparam int CW = $clog2(MAX_TRIES + 1);
    localparam logic [CW-1:0]        CNT_MAX = CW'(MAX_TRIES);
    localparam logic [MAX_TRIES-1:0] LED_MSB = MAX_TRIES'(1) << (MAX_TRIES - 1);

    state_t                r_state, w_nxt_state;
    logic [4*DIGITS-1:0]   r_snap;
    logic [CW-1:0]         r_cnt, w_nxt_cnt, w_cnt_inc;
    logic [MAX_TRIES-1:0]  r_leds, w_nxt_leds;
    logic                  r_pass, w_nxt_pass;
    logic                  r_alarm, w_nxt_alarm;
    logic                  r_busy;
    logic                  w_snap_ld, w_buf_clr, w_buf_wr, w_buf_full;
    logic [4*DIGITS-1:0]   w_entry;
    logic [DIGITS-1:0]     w_seat;

    pwd_entry_buf #(.DIGITS(DIGITS)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_buf_clr),
        .i_wr    (w_buf_wr),
        .i_dat   (key_num),
        .o_entry (w_entry),
        .o_seat  (w_seat),
        .o_full  (w_buf_full)
    );

`ifdef PWD_LOCKOUT_TIMER_EN
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    logic [TW-1:0] r_tmr;

    // Preloaded while outside LOCKED so the first locked cycle already holds LOCK_CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_tmr <= '0;
        else if (r_state != ST_LOCKED)  r_tmr <= TW'(LOCK_CYCLES - 1);
        else if (r_tmr != '0)           r_tmr <= r_tmr - TW'(1);
    end
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_leds  = r_leds;
        w_nxt_pass  = r_pass;
        w_nxt_alarm = r_alarm;
        w_snap_ld   = 1'b0;
        w_buf_clr   = 1'b0;
        w_buf_wr    = 1'b0;
        w_cnt_inc   = r_cnt + CW'(1);
        case (r_state)
            ST_LOCKED: begin
`ifdef PWD_LOCKOUT_TIMER_EN
                if (r_tmr == '0) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_alarm = 1'b0;
                    w_nxt_leds  = '0;
                    w_nxt_cnt   = '0;
                end
`endif
            end
            default: begin
                if (check) begin
                    w_snap_ld   = 1'b1;
                    w_buf_clr   = 1'b1;
                    w_nxt_pass  = 1'b0;
                    w_nxt_state = ST_ENTRY;
                end else if (set) begin
                    w_buf_clr   = 1'b1;
                    w_nxt_pass  = 1'b0;
                    w_nxt_leds  = '0;
                    w_nxt_cnt   = '0;
                    w_nxt_state = ST_IDLE;
                end else if (confirm && (r_state == ST_ENTRY || r_state == ST_WAIT_CFM)) begin
                    if (r_state == ST_WAIT_CFM && w_entry == r_snap) begin
                        w_nxt_pass  = 1'b1;
                        w_nxt_leds  = '0;
                        w_nxt_cnt   = '0;
                        w_nxt_state = ST_PASS;
                    end else begin
                        // short entries and mismatches count alike
                        w_nxt_cnt  = w_cnt_inc;
                        w_nxt_leds = (r_leds >> 1) | LED_MSB;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_nxt_alarm = 1'b1;
                            w_nxt_state = ST_LOCKED;
                        end else begin
                            w_buf_clr   = 1'b1;
                            w_nxt_state = ST_ENTRY;
                        end
                    end
                end else if (key_en && r_state == ST_ENTRY) begin
                    w_buf_wr = 1'b1;
                    if (w_buf_full) w_nxt_state = ST_WAIT_CFM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_snap  <= '0;
            r_cnt   <= '0;
            r_leds  <= '0;
            r_pass  <= 1'b0;
            r_alarm <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_leds  <= w_nxt_leds;
            r_pass  <= w_nxt_pass;
            r_alarm <= w_nxt_alarm;
            r_busy  <= (w_nxt_state == ST_ENTRY) || (w_nxt_state == ST_WAIT_CFM);
            if (w_snap_ld) r_snap <= set_code;
        end
    end

    assign entry     = w_entry;
    assign seat      = w_seat;
    assign busy      = r_busy;
    assign pass      = r_pass;
    assign fail_leds = r_leds;
    assign alarm     = r_alarm;

endmodule

// File: tb/tb_pwd_checker_n.sv
// Bench for pwd_checker_n: directed scenarios plus randomized traffic against a behavioural model.
module tb_pwd_checker_n;

    localparam int DIGITS      = 3;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 8;
    localparam int W           = 4 * DIGITS;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_WAIT = 2, M_PASS = 3, M_LOCK = 4;

    logic clk = 1'b0;
    logic rst, set, check, confirm, key_en;
    logic [3:0] key_num;
    logic [W-1:0] set_code;
    logic [W-1:0] entry;
    logic [DIGITS-1:0] seat;
    logic busy, pass, alarm;
    logic [MAX_TRIES-1:0] fail_leds;

    int checks = 0;
    int failures = 0;

    int         m_st;
    int         m_fails;
    int         m_lock_age;
    logic       m_pass, m_alarm;
    logic [W-1:0] m_snap;
    logic [3:0] m_dig[$];
    bit         m_after_rst;

    pwd_checker_n #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .clk(clk), .rst(rst), .set(set), .check(check), .confirm(confirm),
        .key_en(key_en), .key_num(key_num), .set_code(set_code),
        .entry(entry), .seat(seat), .busy(busy), .pass(pass),
        .fail_leds(fail_leds), .alarm(alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    task automatic m_reset();
        m_st = M_IDLE; m_fails = 0; m_pass = 0; m_alarm = 0; m_snap = '0;
        m_dig.delete(); m_after_rst = 1; m_lock_age = 0;
    endtask

    task automatic m_clear();
        m_dig.delete();
        m_after_rst = 0;
    endtask

    task automatic model_step(input logic s, input logic c, input logic cf, input logic ke,
                              input logic [3:0] kn, input logic [W-1:0] code);
        logic [W-1:0] val;
        if (m_st == M_LOCK) begin
`ifdef PWD_LOCKOUT_TIMER_EN
            m_lock_age++;
            if (m_lock_age == LOCK_CYCLES) begin
                m_alarm = 0; m_fails = 0; m_st = M_IDLE;
            end
`endif
        end else if (c) begin
            m_snap = code; m_clear(); m_pass = 0; m_st = M_ENTRY;
        end else if (s) begin
            m_pass = 0; m_fails = 0; m_clear(); m_st = M_IDLE;
        end else if (cf && (m_st == M_ENTRY || m_st == M_WAIT)) begin
            val = '0;
            foreach (m_dig[i]) val = (val << 4) | W'(m_dig[i]);
            if (m_st == M_WAIT && val == m_snap) begin
                m_pass = 1; m_fails = 0; m_st = M_PASS;
            end else begin
                m_fails++;
                if (m_fails == MAX_TRIES) begin
                    m_alarm = 1; m_st = M_LOCK; m_lock_age = 0;
                end else begin
                    m_clear(); m_st = M_ENTRY;
                end
            end
        end else if (ke && m_st == M_ENTRY) begin
            m_dig.push_back(kn);
            if (m_dig.size() == DIGITS) m_st = M_WAIT;
        end
    endtask

    function automatic logic [W-1:0] exp_entry();
        logic [W-1:0] v;
        v = '1;
        if (!m_after_rst)
            for (int i = 0; i < DIGITS; i++)
                v[W-1-4*i -: 4] = (i < m_dig.size()) ? m_dig[i] : 4'hE;
        return v;
    endfunction

    function automatic logic [DIGITS-1:0] exp_seat();
        logic [DIGITS-1:0] v;
        v = '1;
        for (int i = 0; i < m_dig.size(); i++) v[DIGITS-1-i] = 1'b0;
        return v;
    endfunction

    function automatic logic [MAX_TRIES-1:0] exp_leds();
        logic [MAX_TRIES-1:0] v;
        v = '0;
        for (int i = 0; i < m_fails; i++) v[MAX_TRIES-1-i] = 1'b1;
        return v;
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick(input logic s, input logic c, input logic cf, input logic ke, input logic [3:0] kn);
        set = s; check = c; confirm = cf; key_en = ke; key_num = kn;
        @(posedge clk);
        #1;
        model_step(s, c, cf, ke, kn, set_code);
        set = 0; check = 0; confirm = 0; key_en = 0;
    endtask

    task automatic key(input logic [3:0] kn);
        tick(0, 0, 0, 1, kn);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        m_reset();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        pulse_rst();
        checks++; if (entry !== '1) begin failures++; $display("FAIL reset_entry got=%h exp=%h", entry, {W{1'b1}}); end
        checks++; if (seat !== '1) begin failures++; $display("FAIL reset_seat got=%b exp=111", seat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
        checks++; if (fail_leds !== '0) begin failures++; $display("FAIL reset_leds got=%b exp=000", fail_leds); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        release_rst();
    endtask

    task automatic test_correct_code();
        set_code = 12'h123;
        tick(0, 1, 0, 0, 0);
        checks++; if (entry !== 12'hEEE || busy !== 1'b1) begin failures++; $display("FAIL check_start entry=%h busy=%b exp=eee/1", entry, busy); end
        key(4'h1);
        checks++; if (entry !== 12'h1EE || seat !== 3'b011) begin failures++; $display("FAIL first_key entry=%h seat=%b exp=1ee/011", entry, seat); end
        key(4'h2); key(4'h3);
        checks++; if (seat !== 3'b000 || entry !== 12'h123) begin failures++; $display("FAIL correct_entry seat=%b entry=%h exp=000/123", seat, entry); end
        tick(0, 0, 1, 0, 0);
        checks++; if (pass !== 1'b1 || fail_leds !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL correct_pass pass=%b leds=%b busy=%b exp=1/000/0", pass, fail_leds, busy); end
    endtask

    task automatic test_wrong_then_right();
        tick(1, 0, 0, 0, 0);
        set_code = 12'h456;
        tick(0, 1, 0, 0, 0);
        key(4'h4); key(4'h5); key(4'h7);
        tick(0, 0, 1, 0, 0);
        checks++; if (fail_leds !== 3'b100 || entry !== 12'hEEE || seat !== 3'b111 || pass !== 1'b0) begin
            failures++; $display("FAIL wrong_code leds=%b entry=%h seat=%b pass=%b exp=100/eee/111/0", fail_leds, entry, seat, pass); end
        key(4'h4); key(4'h5); key(4'h6);
        tick(0, 0, 1, 0, 0);
        checks++; if (pass !== 1'b1 || fail_leds !== 3'b000) begin failures++; $display("FAIL retry_right pass=%b leds=%b exp=1/000", pass, fail_leds); end
    endtask

    task automatic test_short_entry();
        tick(1, 0, 0, 0, 0);
        set_code = 12'h789;
        tick(0, 1, 0, 0, 0);
        key(4'h1);
        tick(0, 0, 1, 0, 0);
        checks++; if (fail_leds !== 3'b100 || seat !== 3'b111 || busy !== 1'b1) begin failures++; $display("FAIL short_entry leds=%b seat=%b busy=%b exp=100/111/1", fail_leds, seat, busy); end
        key(4'h2);
        checks++; if (entry !== 12'h2EE) begin failures++; $display("FAIL short_index_reset entry=%h exp=2ee", entry); end
    endtask

    task automatic test_zero_latency();
        tick(1, 0, 0, 0, 0);
        set_code = 12'h123;
        tick(0, 1, 0, 0, 0);
        key(4'h1); key(4'h2);
        tick(0, 0, 1, 1, 4'h3);
        checks++; if (fail_leds !== 3'b100 || pass !== 1'b0 || entry !== 12'hEEE) begin failures++; $display("FAIL same_edge_confirm leds=%b pass=%b entry=%h exp=100/0/eee", fail_leds, pass, entry); end
    endtask

    task automatic test_check_set_in_pass();
        tick(1, 0, 0, 0, 0);
        set_code = 12'hAE0;
        tick(0, 1, 0, 0, 0);
        key(4'hA); key(4'hE); key(4'h0);
        tick(0, 0, 1, 0, 0);
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL blank_digit_match pass=%b exp=1", pass); end
        tick(1, 1, 0, 0, 0);
        checks++; if (pass !== 1'b0 || busy !== 1'b1 || entry !== 12'hEEE) begin failures++; $display("FAIL check_beats_set pass=%b busy=%b entry=%h exp=0/1/eee", pass, busy, entry); end
    endtask

    task automatic test_lockout();
        logic [MAX_TRIES-1:0] exp_l [3];
        exp_l[0] = 3'b100; exp_l[1] = 3'b110; exp_l[2] = 3'b111;
        tick(1, 0, 0, 0, 0);
        set_code = 12'h321;
        tick(0, 1, 0, 0, 0);
        for (int t = 0; t < 3; t++) begin
            key(4'h0); key(4'h0); key(4'h0);
            tick(0, 0, 1, 0, 0);
            checks++; if (fail_leds !== exp_l[t]) begin failures++; $display("FAIL lockout_leds try=%0d got=%b exp=%b", t, fail_leds, exp_l[t]); end
        end
        checks++; if (alarm !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL lockout_alarm alarm=%b busy=%b exp=1/0", alarm, busy); end
        tick(0, 1, 0, 0, 0); tick(1, 0, 0, 0, 0); key(4'h3);
        checks++; if (alarm !== 1'b1 || fail_leds !== 3'b111 || busy !== 1'b0 || entry !== 12'h000) begin
            failures++; $display("FAIL locked_ignores alarm=%b leds=%b busy=%b entry=%h exp=1/111/0/000", alarm, fail_leds, busy, entry); end
`ifdef PWD_LOCKOUT_TIMER_EN
        for (int n = 4; n <= LOCK_CYCLES; n++) begin
            tick(0, 0, 0, 0, 0);
            checks++; if (alarm !== (n < LOCK_CYCLES)) begin failures++; $display("FAIL lock_timer cycle=%0d alarm=%b exp=%b", n, alarm, n < LOCK_CYCLES); end
        end
        checks++; if (fail_leds !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL lock_timer_exit leds=%b busy=%b exp=000/0", fail_leds, busy); end
        tick(0, 1, 0, 0, 0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL after_timer_check busy=%b exp=1", busy); end
`else
        for (int n = 0; n < 20; n++) tick(0, 0, 0, 0, 0);
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL lock_persists alarm=%b exp=1", alarm); end
`endif
        pulse_rst();
        checks++; if (alarm !== 1'b0 || fail_leds !== 3'b000 || entry !== 12'hFFF) begin
            failures++; $display("FAIL rst_clears alarm=%b leds=%b entry=%h exp=0/000/fff", alarm, fail_leds, entry); end
        release_rst();
    endtask

    task automatic test_random();
        logic s, c, cf, ke;
        logic [3:0] kn;
        int locked_for;
        locked_for = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_rst();
                checks++; if (entry !== '1 || seat !== '1 || fail_leds !== '0 || alarm !== 1'b0) begin
                    failures++; $display("FAIL rand_rst cyc=%0d entry=%h seat=%b leds=%b alarm=%b", cyc, entry, seat, fail_leds, alarm); end
                release_rst();
            end
            if (m_st == M_LOCK) locked_for++; else locked_for = 0;
            if (locked_for > 30) begin
                pulse_rst();
                release_rst();
                locked_for = 0;
            end
            if ($urandom_range(0, 3) == 0) set_code = W'($urandom);
            c  = ($urandom_range(0, 99) < 4);
            s  = ($urandom_range(0, 99) < 3);
            cf = ($urandom_range(0, 99) < 12);
            ke = ($urandom_range(0, 99) < 50);
            if (m_dig.size() < DIGITS && $urandom_range(0, 9) < 8)
                kn = m_snap[W-1-4*m_dig.size() -: 4];
            else
                kn = 4'($urandom);
            tick(s, c, cf, ke, kn);
            checks++; if (entry !== exp_entry()) begin failures++; $display("FAIL rand_entry cyc=%0d got=%h exp=%h", cyc, entry, exp_entry()); end
            checks++; if (seat !== exp_seat()) begin failures++; $display("FAIL rand_seat cyc=%0d got=%b exp=%b", cyc, seat, exp_seat()); end
            checks++; if (busy !== (m_st == M_ENTRY || m_st == M_WAIT)) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, m_st == M_ENTRY || m_st == M_WAIT); end
            checks++; if (pass !== m_pass) begin failures++; $display("FAIL rand_pass cyc=%0d got=%b exp=%b", cyc, pass, m_pass); end
            checks++; if (fail_leds !== exp_leds()) begin failures++; $display("FAIL rand_leds cyc=%0d got=%b exp=%b", cyc, fail_leds, exp_leds()); end
            checks++; if (alarm !== m_alarm) begin failures++; $display("FAIL rand_alarm cyc=%0d got=%b exp=%b", cyc, alarm, m_alarm); end
        end
    endtask

    initial begin
        rst = 0; set = 0; check = 0; confirm = 0; key_en = 0; key_num = '0; set_code = '0;
        m_reset();
        test_reset();
        test_correct_code();
        test_wrong_then_right();
        test_short_entry();
        test_zero_latency();
        test_check_set_in_pass();
        test_lockout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
